comb_buffer_ctrl: RTL and testbench



---
 rtl/comb_buffer_ctrl.sv | 168 ++++++++++++++++
 tb/tb_comb_buffer_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_buffer_ctrl.sv
// Read-modify-write sequencer for the comb-filter sample buffer: inserts one
// sample per request into its BRAM line, then fetches and returns the delayed tap sample.
module comb_buffer_ctrl #(
    parameter int LINE_WIDTH   = 1024,
    parameter int WORD_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  sample_valid_in,
    input  logic [WORD_WIDTH-1:0] audio_in,
    input  logic [15:0]           delay_in,
    output logic                  busy_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                  mem_we_out,
    output logic [LINE_WIDTH-1:0] mem_wdata_out,
    input  logic [LINE_WIDTH-1:0] mem_rdata_in,
    output logic [LINE_WIDTH-1:0] merge_line_out,
    output logic [WORD_WIDTH-1:0] merge_audio_out,
    output logic [15:0]           merge_index_out,
    input  logic [LINE_WIDTH-1:0] merge_line_in,
    output logic [WORD_WIDTH-1:0] tap_sample_out,
    output logic                  tap_valid_out,
    output logic [15:0]           wr_index_out,
    output logic                  overrun_out
);

    localparam int WORD_SEL_W = $clog2(LINE_WIDTH / WORD_WIDTH);
    localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        MERGE,
        WRITE,
        TAP_ADDR,
        TAP_WAIT,
        TAP_OUT
    } state_t;

    state_t                state_q;
    logic [2:0]            waitCnt_q;
    logic [15:0]           wrIndex_q;
    logic [15:0]           wrIndex_d;
    logic [15:0]           index_q;
    logic [15:0]           delay_q;
    logic [WORD_WIDTH-1:0] audio_q;
    logic [ADDR_WIDTH-1:0] memAddr_q;
    logic                  memWe_q;
    logic [LINE_WIDTH-1:0] memWdata_q;
    logic [LINE_WIDTH-1:0] mergeLine_q;
    logic [WORD_WIDTH-1:0] tapSample_q;
    logic                  tapValid_q;
    logic                  busy_q;
    logic                  overrun_q;

    logic [15:0]           tapIndex;
    logic [WORD_WIDTH-1:0] tapWord;
    logic                  tapDone;

    assign tapIndex = index_q - delay_q;
    assign tapWord  = mem_rdata_in[tapIndex[WORD_SEL_W-1:0] * WORD_WIDTH +: WORD_WIDTH];
    assign tapDone  = (state_q == TAP_WAIT) && (waitCnt_q == WAIT_LAST);

    // The write index only advances as the tap result is handed out.
    always_comb begin
        wrIndex_d = wrIndex_q;
        if (tapDone) begin
            wrIndex_d = wrIndex_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            waitCnt_q   <= '0;
            wrIndex_q   <= '0;
            index_q     <= '0;
            delay_q     <= '0;
            audio_q     <= '0;
            memAddr_q   <= '0;
            memWe_q     <= 1'b0;
            memWdata_q  <= '0;
            mergeLine_q <= '0;
            tapSample_q <= '0;
            tapValid_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            memWe_q    <= 1'b0;
            tapValid_q <= 1'b0;
            wrIndex_q  <= wrIndex_d;
            if (sample_valid_in && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (sample_valid_in) begin
                        audio_q   <= audio_in;
                        delay_q   <= delay_in;
                        index_q   <= wrIndex_q;
                        memAddr_q <= wrIndex_q[WORD_SEL_W +: ADDR_WIDTH];
                        busy_q    <= 1'b1;
                        state_q   <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    waitCnt_q <= '0;
                    state_q   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (waitCnt_q == WAIT_LAST) begin
                        mergeLine_q <= mem_rdata_in;
                        state_q     <= MERGE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 3'd1;
                    end
                end
                MERGE: begin
                    memWdata_q <= merge_line_in;
                    memWe_q    <= 1'b1;
                    state_q    <= WRITE;
                end
                // The write lands before the tap address is issued, so a zero delay reads back the new sample.
                WRITE: begin
                    memAddr_q <= tapIndex[WORD_SEL_W +: ADDR_WIDTH];
                    state_q   <= TAP_ADDR;
                end
                TAP_ADDR: begin
                    waitCnt_q <= '0;
                    state_q   <= TAP_WAIT;
                end
                TAP_WAIT: begin
                    if (tapDone) begin
                        tapSample_q <= tapWord;
                        tapValid_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= TAP_OUT;
                    end else begin
                        waitCnt_q <= waitCnt_q + 3'd1;
                    end
                end
                TAP_OUT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_out        = busy_q;
    assign mem_addr_out    = memAddr_q;
    assign mem_we_out      = memWe_q;
    assign mem_wdata_out   = memWdata_q;
    assign merge_line_out  = mergeLine_q;
    assign merge_audio_out = audio_q;
    assign merge_index_out = index_q;
    assign tap_sample_out  = tapSample_q;
    assign tap_valid_out   = tapValid_q;
    assign wr_index_out    = wrIndex_q;
    assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_comb_buffer_ctrl.sv
// Bench for comb_buffer_ctrl: BRAM and merge-datapath models around the DUT,
// a table of hand-computed vectors plus directed overrun, reset and wrap sequences.
module tb_comb_buffer_ctrl;

    localparam int RL    = 2;
    localparam int LW    = 1024;
    localparam int AW    = 10;
    localparam int LINES = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sampleValid = 1'b0;
    logic [15:0]   audioIn = '0;
    logic [15:0]   delayIn = '0;
    logic          busyOut;
    logic [AW-1:0] memAddr;
    logic          memWe;
    logic [LW-1:0] memWdata;
    logic [LW-1:0] memRdata;
    logic [LW-1:0] mergeLineOut;
    logic [15:0]   mergeAudio;
    logic [15:0]   mergeIndex;
    logic [LW-1:0] mergeLineIn;
    logic [15:0]   tapSample;
    logic          tapValid;
    logic [15:0]   wrIndex;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    logic          bramClear = 1'b1;
    logic [LW-1:0] bram [LINES];
    logic [LW-1:0] rdPipe [RL];
    logic [15:0]   model [65536];
    logic [15:0]   expIdx = '0;

    typedef struct {
        logic [15:0]   audio;
        logic [15:0]   delay;
        logic [15:0]   expTap;
        logic [AW-1:0] expLine;
        logic [15:0]   expWr;
    } vec_t;

    vec_t vecs [7];

    comb_buffer_ctrl #(.READ_LATENCY(RL)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .sample_valid_in (sampleValid),
        .audio_in        (audioIn),
        .delay_in        (delayIn),
        .busy_out        (busyOut),
        .mem_addr_out    (memAddr),
        .mem_we_out      (memWe),
        .mem_wdata_out   (memWdata),
        .mem_rdata_in    (memRdata),
        .merge_line_out  (mergeLineOut),
        .merge_audio_out (mergeAudio),
        .merge_index_out (mergeIndex),
        .merge_line_in   (mergeLineIn),
        .tap_sample_out  (tapSample),
        .tap_valid_out   (tapValid),
        .wr_index_out    (wrIndex),
        .overrun_out     (overrun)
    );

    always #5 clk = ~clk;

    // Single-port BRAM: read-before-write, data appears RL cycles after the address.
    always @(posedge clk) begin
        if (bramClear) begin
            for (int i = 0; i < LINES; i++) bram[i] <= '0;
            for (int i = 0; i < RL; i++) rdPipe[i] <= '0;
        end else begin
            if (memWe) bram[memAddr] <= memWdata;
            rdPipe[0] <= bram[memAddr];
            for (int i = 1; i < RL; i++) rdPipe[i] <= rdPipe[i-1];
        end
    end
    assign memRdata = rdPipe[RL-1];

    // Word-insert merge datapath.
    always_comb begin
        mergeLineIn = mergeLineOut;
        mergeLineIn[{mergeIndex[5:0], 4'b0000} +: 16] = mergeAudio;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] audio, input logic [15:0] delay, input int extraAt,
                                 input logic [15:0] expTap, input logic [AW-1:0] expLine,
                                 input logic [15:0] expWr, input logic expOv, input string label);
        int          cyc;
        int          weCount;
        int          weCyc;
        int          tapCyc;
        logic [15:0] idx;
        logic [AW-1:0] rdAddr;
        logic [AW-1:0] weAddr;
        logic [15:0] wdataWord;
        logic [15:0] mIdx;
        logic [15:0] mAud;
        logic [15:0] tapVal;
        logic [15:0] wrAtTap;
        logic        busyAt1;
        logic        busyAtTap;
        idx = expIdx;
        rdAddr = '0; weAddr = '0; wdataWord = '0; mIdx = '0; mAud = '0;
        tapVal = '0; wrAtTap = '0; busyAt1 = 1'b0; busyAtTap = 1'b1;
        @(negedge clk);
        sampleValid = 1'b1;
        audioIn = audio;
        delayIn = delay;
        @(negedge clk);
        sampleValid = 1'b0;
        audioIn = 16'hDEAD;
        cyc = 1; weCount = 0; weCyc = -1; tapCyc = -1;
        while (tapCyc < 0 && cyc < 40) begin
            if (cyc == 1) begin
                rdAddr = memAddr;
                busyAt1 = busyOut;
            end
            if (memWe) begin
                weCount++;
                weCyc = cyc;
                weAddr = memAddr;
                wdataWord = memWdata[{idx[5:0], 4'b0000} +: 16];
                mIdx = mergeIndex;
                mAud = mergeAudio;
            end
            if (tapValid) begin
                tapCyc = cyc;
                tapVal = tapSample;
                busyAtTap = busyOut;
                wrAtTap = wrIndex;
            end
            sampleValid = (cyc == extraAt);
            if (tapCyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        sampleValid = 1'b0;
        checkOutput({label, " rdAddr"}, 32'(rdAddr), 32'(expLine));
        checkOutput({label, " busyC1"}, 32'(busyAt1), 32'd1);
        checkOutput({label, " weCount"}, 32'(weCount), 32'd1);
        checkOutput({label, " weCycle"}, 32'(weCyc), 32'(3 + RL));
        checkOutput({label, " weAddr"}, 32'(weAddr), 32'(expLine));
        checkOutput({label, " wdataWord"}, 32'(wdataWord), 32'(audio));
        checkOutput({label, " mergeIdx"}, 32'(mIdx), 32'(idx));
        checkOutput({label, " mergeAud"}, 32'(mAud), 32'(audio));
        checkOutput({label, " tapCycle"}, 32'(tapCyc), 32'(5 + 2 * RL));
        checkOutput({label, " tapSample"}, 32'(tapVal), 32'(expTap));
        checkOutput({label, " busyAtTap"}, 32'(busyAtTap), 32'd0);
        checkOutput({label, " wrIndex"}, 32'(wrAtTap), 32'(expWr));
        checkOutput({label, " tapStrobe"}, 32'(tapValid), 32'd0);
        checkOutput({label, " overrun"}, 32'(overrun), 32'(expOv));
        model[idx] = audio;
        expIdx = idx + 16'd1;
    endtask

    task automatic runModel(input logic [15:0] audio, input logic [15:0] delay, input int extraAt,
                            input logic expOv, input string label);
        logic [15:0] idx;
        logic [15:0] tIdx;
        logic [15:0] expTap;
        logic [15:0] nxt;
        idx = expIdx;
        tIdx = idx - delay;
        expTap = (tIdx == idx) ? audio : model[tIdx];
        nxt = idx + 16'd1;
        applyStimulus(audio, delay, extraAt, expTap, idx[15:6], nxt, expOv, label);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expIdx = '0;
    endtask

    initial begin
        int weSeen;
        int tapSeen;
        vecs[0] = '{16'h1234, 16'd0, 16'h1234, 10'd0, 16'd1};
        vecs[1] = '{16'hBEEF, 16'd1, 16'h1234, 10'd0, 16'd2};
        vecs[2] = '{16'h8000, 16'd2, 16'h1234, 10'd0, 16'd3};
        vecs[3] = '{16'h7FFF, 16'd0, 16'h7FFF, 10'd0, 16'd4};
        vecs[4] = '{16'h0001, 16'd3, 16'hBEEF, 10'd0, 16'd5};
        vecs[5] = '{16'hAAAA, 16'd2, 16'h7FFF, 10'd0, 16'd6};
        vecs[6] = '{16'h5555, 16'd7, 16'h0000, 10'd0, 16'd7};
        for (int i = 0; i < 65536; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        bramClear = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", 32'(busyOut), 32'd0);
        checkOutput("reset we", 32'(memWe), 32'd0);
        checkOutput("reset addr", 32'(memAddr), 32'd0);
        checkOutput("reset tapValid", 32'(tapValid), 32'd0);
        checkOutput("reset tapSample", 32'(tapSample), 32'd0);
        checkOutput("reset wrIndex", 32'(wrIndex), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        checkOutput("reset mergeIdx", 32'(mergeIndex), 32'd0);
        checkOutput("reset mergeAud", 32'(mergeAudio), 32'd0);
        checkOutput("reset mergeLine", 32'(|mergeLineOut), 32'd0);
        checkOutput("reset wdata", 32'(|memWdata), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].audio, vecs[i].delay, -1, vecs[i].expTap, vecs[i].expLine,
                          vecs[i].expWr, 1'b0, $sformatf("vec%0d", i));
        end

        doReset();
        for (int i = 0; i < 65; i++) begin
            runModel(16'(i), 16'd1, -1, 1'b0, $sformatf("seq%0d", i));
        end

        runModel(16'h0A0A, 16'd2, 3, 1'b1, "overrunC3");
        runModel(16'h0B0B, 16'd0, -1, 1'b1, "overrunSticky");

        @(negedge clk);
        sampleValid = 1'b1;
        audioIn = 16'h9999;
        delayIn = 16'd0;
        @(negedge clk);
        sampleValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        weSeen = 0;
        tapSeen = 0;
        for (int i = 0; i < 20; i++) begin
            if (memWe) weSeen++;
            if (tapValid) tapSeen++;
            @(negedge clk);
        end
        checkOutput("midReset weCount", 32'(weSeen), 32'd0);
        checkOutput("midReset tapCount", 32'(tapSeen), 32'd0);
        checkOutput("midReset wrIndex", 32'(wrIndex), 32'd0);
        checkOutput("midReset busy", 32'(busyOut), 32'd0);
        checkOutput("midReset overrun", 32'(overrun), 32'd0);
        expIdx = '0;
        runModel(16'h0C0C, 16'd1, -1, 1'b0, "afterReset");

        runModel(16'h0D0D, 16'd1, 5 + 2 * RL, 1'b1, "overrunTapOut");

        @(negedge clk);
        force dut.wrIndex_q = 16'hFFFF;
        @(negedge clk);
        release dut.wrIndex_q;
        @(negedge clk);
        checkOutput("preload wrIndex", 32'(wrIndex), 32'hFFFF);
        expIdx = 16'hFFFF;
        runModel(16'h0E0E, 16'hFFFF, -1, 1'b1, "wrapWrite");
        runModel(16'h0F0F, 16'd1, -1, 1'b1, "wrapNext");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
